// File: rtl/mux2_1_pkg.sv
// Shared constants for the mux2_1 slice: selection-counter width, its
// saturation value and a saturating increment helper.
package mux2_1_pkg;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/mux2_1_bit.sv
// Single-bit two-input multiplexer built from AND/OR/NOT gates so the
// output is fully defined for every 0/1 input combination.
module mux2_1_bit (
  input  logic i0_i,
  input  logic i1_i,
  input  logic sel_i,
  output logic out_o
);
  assign out_o = (i0_i & ~sel_i) | (i1_i & sel_i);
endmodule

// File: rtl/mux2_1.sv
// WIDTH-bit 2:1 mux with a registered copy of its output. Defining
// MUX2_1_STATS_EN compiles in a saturating counter of sampled sel transitions.
module mux2_1
  import mux2_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] sel_changes
);
  logic [WIDTH-1:0] data_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    mux2_1_bit u_bit (
      .i0_i (i0[g]),
      .i1_i (i1[g]),
      .sel_i(sel),
      .out_o(out[g])
    );
  end

  // Registered copy of the combinational result
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= out;
  end
  assign out_q = data_q;

`ifdef MUX2_1_STATS_EN
  logic             prev_sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sel != prev_sel_q) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sel_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prev_sel_q <= sel;
      cnt_q      <= cnt_d;
    end
  end
  assign sel_changes = cnt_q;
`else
  assign sel_changes = '0;
`endif
endmodule

// File: tb/tb_mux2_1.sv
// Scoreboard bench for mux2_1 at widths 64, 4 and 1 sharing one stimulus stream.
module tb_mux2_1;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] i0 = '0, i1 = '0;
  logic        sel = 1'b0;
  logic [63:0] out64, outq64;
  logic [3:0]  out4, outq4;
  logic [0:0]  out1, outq1;
  logic [15:0] cnt64, cnt4, cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] q;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  // Reference state: sampled sel history reduced to a transition count
  int  ref_cnt  = 0;
  logic ref_prev = 1'b0;

  always #5 clk = ~clk;

  mux2_1 #(.WIDTH(64)) u_dut (.clk(clk), .reset(reset), .i0(i0), .i1(i1), .sel(sel),
                              .out(out64), .out_q(outq64), .sel_changes(cnt64));
  mux2_1 #(.WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .i0(i0[3:0]), .i1(i1[3:0]), .sel(sel),
                            .out(out4), .out_q(outq4), .sel_changes(cnt4));
  mux2_1 #(.WIDTH(1)) u_w1 (.clk(clk), .reset(reset), .i0(i0[0:0]), .i1(i1[0:0]), .sel(sel),
                            .out(out1), .out_q(outq1), .sel_changes(cnt1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_comb();
    logic [63:0] e;
    e = sel ? i1 : i0;
    chk("out64", out64, e);
    chk("out4", {60'd0, out4}, {60'd0, e[3:0]});
    chk("out1", {63'd0, out1}, {63'd0, e[0]});
  endtask

  // One clock of stimulus: drive at negedge, optionally change sel and data
  // again before the edge, then record what the next edge must register.
  task automatic drive(input logic r, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic flip);
    exp_t e;
    @(negedge clk);
    reset = r; i0 = a; i1 = b; sel = s;
    #1 chk_comb();
    if (flip) begin
      sel = ~sel; i0 = ~i0;
      #1 chk_comb();
    end
    if (r) begin
      ref_cnt = 0; ref_prev = 1'b0;
      e.q = '0;
    end else begin
      if (sel != ref_prev) ref_cnt = (ref_cnt >= 65535) ? 65535 : ref_cnt + 1;
      ref_prev = sel;
      e.q = sel ? i1 : i0;
    end
`ifdef MUX2_1_STATS_EN
    e.cnt = 16'(ref_cnt);
`else
    e.cnt = 16'd0;
`endif
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_q64", outq64, e.q);
        chk("out_q4", {60'd0, outq4}, {60'd0, e.q[3:0]});
        chk("out_q1", {63'd0, outq1}, {63'd0, e.q[0]});
        chk("sel_changes64", {48'd0, cnt64}, {48'd0, e.cnt});
        chk("sel_changes4", {48'd0, cnt4}, {48'd0, e.cnt});
        chk("sel_changes1", {48'd0, cnt1}, {48'd0, e.cnt});
      end
    end
  end

  initial begin : stim
    logic s;
    int   wait_cyc;
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    // Wide all-zero/all-one data, sel flipped mid-cycle without an edge
    drive(1'b0, 64'd0, {64{1'b1}}, 1'b0, 1'b1);
    // Truth table over i0/i1/sel
    for (int k = 0; k < 8; k++)
      drive(1'b0, {64{k[0]}}, {64{k[1]}}, k[2], 1'b0);
    // Reset held with data present, then released
    drive(1'b1, 64'd0, 64'hA, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 64'hA, 1'b1, 1'b0);
    // Randomized traffic with occasional reset and mid-cycle changes
    for (int n = 0; n < 300; n++)
      drive(($urandom_range(0, 24) == 0), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), ($urandom_range(0, 3) == 0));
    // Toggle sel on every edge long enough to reach saturation when counting
    s = 1'b0;
`ifdef MUX2_1_STATS_EN
    for (int n = 0; n < 70000; n++) begin
`else
    for (int n = 0; n < 200; n++) begin
`endif
      s = ~s;
      drive(1'b0, 64'h5, 64'hC, s, 1'b0);
    end
    // Reset, then exactly five toggles
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    s = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s = ~s;
      drive(1'b0, 64'h3, 64'h9, s, 1'b0);
    end
    drive(1'b0, 64'h3, 64'h9, s, 1'b0);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2 chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
